// File: rtl/line_buf_ctrl.sv
// -----------------------------------------------------------------------------
// line_buf_ctrl
// Write/read controller for an 8-bank line-buffer RAM (asynchronous read).
// A raster pixel stream is written one line per bank, with the write bank
// rotating every line. The seven banks not being written hold the previous
// seven lines; they are read at the current column and combined with the
// current pixel into an 8-row vertical column for the downstream window stage.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   pix_valid/pix_sof/pix_data pixel stream in (no back-pressure)
//   ram_ce/ram_we              per-bank enable, bit (7-k) selects bank k
//   ram_addr/ram_wdata         shared column address and write data
//   ram0_rdata..ram7_rdata     asynchronous read data of banks 0..7
//   col_valid/col_data         column out, byte 0 oldest row, byte 7 current
//   col_x/col_y                column and line of byte 7
//   line_done/frame_done       pulses with last column of line / frame
//
// Pipeline: S0 captures the pixel and its counters, S1 drives the RAM port,
// S2 registers the column assembled from the read data of the S1 cycle.
// -----------------------------------------------------------------------------
module line_buf_ctrl #(
    parameter int IMG_W  = 1920,
    parameter int IMG_H  = 1080,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [7:0]        pix_data,
    output logic [7:0]        ram_ce,
    output logic [7:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram0_rdata,
    input  logic [7:0]        ram1_rdata,
    input  logic [7:0]        ram2_rdata,
    input  logic [7:0]        ram3_rdata,
    input  logic [7:0]        ram4_rdata,
    input  logic [7:0]        ram5_rdata,
    input  logic [7:0]        ram6_rdata,
    input  logic [7:0]        ram7_rdata,
    output logic              col_valid,
    output logic [63:0]       col_data,
    output logic [ADDR_W-1:0] col_x,
    output logic [10:0]       col_y,
    output logic              line_done,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [10:0]       Y_LAST = 11'(IMG_H - 1);

    // One-hot write enable: bank k is driven on bit (7-k).
    function automatic logic [7:0] bank_we(input logic [2:0] wb);
        logic [7:0] we;
        case (wb)
            3'd0:    we = 8'h80;
            3'd1:    we = 8'h40;
            3'd2:    we = 8'h20;
            3'd3:    we = 8'h10;
            3'd4:    we = 8'h08;
            3'd5:    we = 8'h04;
            3'd6:    we = 8'h02;
            3'd7:    we = 8'h01;
            default: we = 8'h00;
        endcase
        return we;
    endfunction

    // Pick the read byte of bank b out of the packed read bus (bank k at byte k).
    function automatic logic [7:0] sel_bank(input logic [2:0] b, input logic [63:0] rd_all);
        logic [7:0] v;
        case (b)
            3'd0:    v = rd_all[7:0];
            3'd1:    v = rd_all[15:8];
            3'd2:    v = rd_all[23:16];
            3'd3:    v = rd_all[31:24];
            3'd4:    v = rd_all[39:32];
            3'd5:    v = rd_all[47:40];
            3'd6:    v = rd_all[55:48];
            3'd7:    v = rd_all[63:56];
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // raster counters
    logic [ADDR_W-1:0] r_x;
    logic [10:0]       r_y;
    logic [2:0]        r_wb;
    logic [2:0]        r_fill;

    // S0 capture
    logic              r_s0_valid;
    logic [7:0]        r_s0_pix;
    logic [ADDR_W-1:0] r_s0_x;
    logic [10:0]       r_s0_y;
    logic [2:0]        r_s0_wb;
    logic              r_s0_full;

    // S1 RAM port and side information
    logic              r_s1_active;
    logic [7:0]        r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [7:0]        r_ram_wdata;
    logic [10:0]       r_s1_y;
    logic [2:0]        r_s1_wb;
    logic              r_s1_full;

    // S2 outputs
    logic              r_col_valid;
    logic [63:0]       r_col_data;
    logic [ADDR_W-1:0] r_col_x;
    logic [10:0]       r_col_y;
    logic              r_line_done;
    logic              r_frame_done;

    logic [ADDR_W-1:0] w_x_cur;
    logic [10:0]       w_y_cur;
    logic [2:0]        w_wb_cur;
    logic [2:0]        w_fill_cur;
    logic [ADDR_W-1:0] w_x_nxt;
    logic [10:0]       w_y_nxt;
    logic [2:0]        w_wb_nxt;
    logic [2:0]        w_fill_nxt;
    logic [63:0]       w_rd_all;
    logic [63:0]       w_col_next;
    logic              w_emit;

    assign w_rd_all = {ram7_rdata, ram6_rdata, ram5_rdata, ram4_rdata,
                       ram3_rdata, ram2_rdata, ram1_rdata, ram0_rdata};
    assign w_emit   = r_s1_active & r_s1_full;

    // Counter values seen by the current pixel (sof restarts everything) and their successors.
    always_comb begin
        w_x_cur    = pix_sof ? '0 : r_x;
        w_y_cur    = pix_sof ? 11'd0 : r_y;
        w_wb_cur   = pix_sof ? 3'd0 : r_wb;
        w_fill_cur = pix_sof ? 3'd0 : r_fill;
        w_x_nxt    = w_x_cur;
        w_y_nxt    = w_y_cur;
        w_wb_nxt   = w_wb_cur;
        w_fill_nxt = w_fill_cur;
        if (w_x_cur == X_LAST) begin
            w_x_nxt    = '0;
            w_wb_nxt   = w_wb_cur + 3'd1;
            w_y_nxt    = (w_y_cur == Y_LAST) ? 11'd0 : w_y_cur + 11'd1;
            w_fill_nxt = (w_fill_cur == 3'd7) ? 3'd7 : w_fill_cur + 3'd1;
        end else begin
            w_x_nxt = w_x_cur + ADDR_W'(1);
        end
    end

    // Counters and S0 capture of each accepted pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_y        <= 11'd0;
            r_wb       <= 3'd0;
            r_fill     <= 3'd0;
            r_s0_valid <= 1'b0;
            r_s0_pix   <= 8'h00;
            r_s0_x     <= '0;
            r_s0_y     <= 11'd0;
            r_s0_wb    <= 3'd0;
            r_s0_full  <= 1'b0;
        end else begin
            r_s0_valid <= pix_valid;
            if (pix_valid) begin
                r_s0_pix  <= pix_data;
                r_s0_x    <= w_x_cur;
                r_s0_y    <= w_y_cur;
                r_s0_wb   <= w_wb_cur;
                r_s0_full <= (w_fill_cur == 3'd7);
                r_x       <= w_x_nxt;
                r_y       <= w_y_nxt;
                r_wb      <= w_wb_nxt;
                r_fill    <= w_fill_nxt;
            end
        end
    end

    // S1: drive the RAM port; address and data hold when no pixel is in S0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_active <= 1'b0;
            r_ram_we    <= 8'h00;
            r_ram_addr  <= '0;
            r_ram_wdata <= 8'h00;
            r_s1_y      <= 11'd0;
            r_s1_wb     <= 3'd0;
            r_s1_full   <= 1'b0;
        end else begin
            r_s1_active <= r_s0_valid;
            if (r_s0_valid) begin
                r_ram_we    <= bank_we(r_s0_wb);
                r_ram_addr  <= r_s0_x;
                r_ram_wdata <= r_s0_pix;
                r_s1_y      <= r_s0_y;
                r_s1_wb     <= r_s0_wb;
                r_s1_full   <= r_s0_full;
            end else begin
                r_ram_we <= 8'h00;
            end
        end
    end

    // Column assembly: byte j comes from bank (wb+1+j) mod 8, i.e. (wb-7+j) mod 8,
    // so the bank under write is never read.
    always_comb begin
        w_col_next = 64'h0;
        for (int j = 0; j < 7; j++) begin
            w_col_next[j*8 +: 8] = sel_bank(r_s1_wb + 3'(j + 1), w_rd_all);
        end
        w_col_next[63:56] = r_ram_wdata;
    end

    // S2: register the column and the end-of-line / end-of-frame pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_valid  <= 1'b0;
            r_col_data   <= 64'h0;
            r_col_x      <= '0;
            r_col_y      <= 11'd0;
            r_line_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_col_valid  <= w_emit;
            r_line_done  <= w_emit & (r_ram_addr == X_LAST);
            r_frame_done <= w_emit & (r_ram_addr == X_LAST) & (r_s1_y == Y_LAST);
            if (w_emit) begin
                r_col_data <= w_col_next;
                r_col_x    <= r_ram_addr;
                r_col_y    <= r_s1_y;
            end
        end
    end

    assign ram_ce     = r_ram_we;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign col_valid  = r_col_valid;
    assign col_data   = r_col_data;
    assign col_x      = r_col_x;
    assign col_y      = r_col_y;
    assign line_done  = r_line_done;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_buf_ctrl
// Bench for line_buf_ctrl with a 16x32 image. Contains an 8-bank RAM model and
// a reference model that keeps the last seven completed lines of the stream
// as a queue and derives position from the pixel count since the last restart.
// -----------------------------------------------------------------------------
module tb_line_buf_ctrl;

    localparam int W  = 16;
    localparam int H  = 32;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic [7:0]    pix_data = 8'h00;
    logic [7:0]    ram_ce, ram_we, ram_wdata;
    logic [AW-1:0] ram_addr, col_x;
    logic [7:0]    rd [8];
    logic          col_valid, line_done, frame_done;
    logic [63:0]   col_data;
    logic [10:0]   col_y;

    line_buf_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_data(pix_data), .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram0_rdata(rd[0]), .ram1_rdata(rd[1]), .ram2_rdata(rd[2]), .ram3_rdata(rd[3]),
        .ram4_rdata(rd[4]), .ram5_rdata(rd[5]), .ram6_rdata(rd[6]), .ram7_rdata(rd[7]),
        .col_valid(col_valid), .col_data(col_data), .col_x(col_x), .col_y(col_y),
        .line_done(line_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // RAM bank model: synchronous write, asynchronous read
    logic [7:0] mem [8][2048];
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (ram_we[7-k]) mem[k][ram_addr] <= ram_wdata;
        end
    end
    always_comb begin
        for (int k = 0; k < 8; k++) rd[k] = mem[k][ram_addr];
    end

    typedef struct packed {
        logic        acc;
        logic [31:0] idx;
        logic [7:0]  we;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic        cv;
        logic [63:0] cd;
        logic [10:0] cx;
        logic [10:0] cy;
        logic        ld;
        logic        fd;
    } rec_t;

    typedef struct {
        int          line;
        int          x;
        logic [7:0]  we;
        logic        cv;
        logic [63:0] cd;
        logic        ld;
        logic        fd;
        logic [10:0] cy;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int           m_idx;
    logic [127:0] lines_q[$];
    logic [127:0] cur_line;
    logic [10:0]  last_addr;
    logic [7:0]   last_wdata;
    rec_t         p1, p2;

    // captures
    int           cap_mode = 0;
    logic [7:0]   cap_we [1024];
    logic         cap_cv [1024];
    logic [63:0]  cap_cd [1024];
    logic         cap_ld [1024];
    logic         cap_fd [1024];
    logic [10:0]  cap_cy [1024];
    logic [63:0]  q_a[$];
    logic [63:0]  q_b[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // one clock cycle: drive inputs, advance model, compare outputs after the edge
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        rec_t a;
        int x, line;
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        a = '0;
        if (!rst_n) begin
            m_idx = 0;
            lines_q.delete();
            cur_line = '0;
            last_addr = '0;
            last_wdata = '0;
            p1 = '0;
            p2 = '0;
        end else if (v) begin
            if (s) begin
                m_idx = 0;
                lines_q.delete();
                cur_line = '0;
            end
            x    = m_idx % W;
            line = m_idx / W;
            a.acc   = 1'b1;
            a.idx   = 32'(m_idx);
            a.we    = 8'h80 >> (line % 8);
            last_addr  = 11'(x);
            last_wdata = d;
            a.cv = (line >= 7);
            if (a.cv) begin
                for (int j = 0; j < 7; j++) begin
                    a.cd[j*8 +: 8] = lines_q[lines_q.size() - 7 + j][x*8 +: 8];
                end
                a.cd[63:56] = d;
                a.cx = 11'(x);
                a.cy = 11'(line % H);
                a.ld = (x == W - 1);
                a.fd = (x == W - 1) && ((line % H) == H - 1);
            end
            cur_line[x*8 +: 8] = d;
            m_idx++;
            if (x == W - 1) begin
                lines_q.push_back(cur_line);
                if (lines_q.size() > 7) void'(lines_q.pop_front());
                cur_line = '0;
            end
        end
        a.addr  = last_addr;
        a.wdata = last_wdata;
        @(posedge clk);
        #1;
        chk("ram_we", 64'(ram_we), 64'(p1.we));
        chk("ram_ce", 64'(ram_ce), 64'(p1.we));
        chk("ram_addr", 64'(ram_addr), 64'(p1.addr));
        chk("ram_wdata", 64'(ram_wdata), 64'(p1.wdata));
        chk("col_valid", 64'(col_valid), 64'(p2.cv));
        chk("line_done", 64'(line_done), 64'(p2.ld));
        chk("frame_done", 64'(frame_done), 64'(p2.fd));
        if (p2.cv) begin
            chk("col_data", col_data, p2.cd);
            chk("col_x", 64'(col_x), 64'(p2.cx));
            chk("col_y", 64'(col_y), 64'(p2.cy));
        end
        if (cap_mode == 1) begin
            if (p1.acc && p1.idx < 1024) cap_we[p1.idx] = ram_we;
            if (p2.acc && p2.idx < 1024) begin
                cap_cv[p2.idx] = col_valid;
                cap_cd[p2.idx] = col_data;
                cap_ld[p2.idx] = line_done;
                cap_fd[p2.idx] = frame_done;
                cap_cy[p2.idx] = col_y;
            end
            if (col_valid) q_a.push_back(col_data);
        end else if (cap_mode == 2) begin
            if (col_valid) q_b.push_back(col_data);
        end
        p2 = p1;
        p1 = a;
    endtask

    function automatic logic [7:0] pat(input int line, input int x);
        return 8'((x + 16 * (line % H)) & 255);
    endfunction

    vec_t tbl [10];

    initial begin
        tbl[0] = '{0,  0,  8'h80, 1'b0, 64'h0,                  1'b0, 1'b0, 11'd0};
        tbl[1] = '{1,  0,  8'h40, 1'b0, 64'h0,                  1'b0, 1'b0, 11'd0};
        tbl[2] = '{6,  15, 8'h02, 1'b0, 64'h0,                  1'b0, 1'b0, 11'd0};
        tbl[3] = '{7,  0,  8'h01, 1'b1, 64'h7060504030201000,   1'b0, 1'b0, 11'd7};
        tbl[4] = '{7,  15, 8'h01, 1'b1, 64'h7F6F5F4F3F2F1F0F,   1'b1, 1'b0, 11'd7};
        tbl[5] = '{8,  0,  8'h80, 1'b1, 64'h8070605040302010,   1'b0, 1'b0, 11'd8};
        tbl[6] = '{9,  3,  8'h40, 1'b1, 64'h9383736353433323,   1'b0, 1'b0, 11'd9};
        tbl[7] = '{30, 15, 8'h02, 1'b1, 64'hEFDFCFBFAF9F8F7F,   1'b1, 1'b0, 11'd30};
        tbl[8] = '{31, 15, 8'h01, 1'b1, 64'hFFEFDFCFBFAF9F8F,   1'b1, 1'b1, 11'd31};
        tbl[9] = '{32, 0,  8'h80, 1'b1, 64'h00F0E0D0C0B0A090,   1'b0, 1'b0, 11'd0};

        // reset with pixels offered: nothing may be accepted
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(i + 8'h5A));
        chk("rst_we", 64'(ram_we), 64'h0);
        chk("rst_ce", 64'(ram_ce), 64'h0);
        chk("rst_addr", 64'(ram_addr), 64'h0);
        chk("rst_wdata", 64'(ram_wdata), 64'h0);
        chk("rst_cv", 64'(col_valid), 64'h0);
        chk("rst_cd", col_data, 64'h0);
        chk("rst_cx", 64'(col_x), 64'h0);
        chk("rst_cy", 64'(col_y), 64'h0);
        chk("rst_ld", 64'({line_done, frame_done}), 64'h0);
        rst_n = 1'b1;

        // gapless run over one frame plus two lines
        cap_mode = 1;
        for (int l = 0; l < 34; l++)
            for (int x = 0; x < W; x++) step(1'b1, 1'b0, pat(l, x));
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        cap_mode = 0;

        // directed table against the captured outputs
        for (int i = 0; i < 10; i++) begin
            int k;
            k = tbl[i].line * W + tbl[i].x;
            chk($sformatf("tbl%0d_we", i), 64'(cap_we[k]), 64'(tbl[i].we));
            chk($sformatf("tbl%0d_cv", i), 64'(cap_cv[k]), 64'(tbl[i].cv));
            chk($sformatf("tbl%0d_ld", i), 64'(cap_ld[k]), 64'(tbl[i].ld));
            chk($sformatf("tbl%0d_fd", i), 64'(cap_fd[k]), 64'(tbl[i].fd));
            if (tbl[i].cv) begin
                chk($sformatf("tbl%0d_cd", i), cap_cd[k], tbl[i].cd);
                chk($sformatf("tbl%0d_cy", i), 64'(cap_cy[k]), 64'(tbl[i].cy));
            end
        end

        // same stream after reset with random gaps between pixels
        rst_n = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        cap_mode = 2;
        for (int l = 0; l < 10; l++)
            for (int x = 0; x < W; x++) begin
                int g;
                g = int'($urandom_range(0, 5));
                for (int i = 0; i < g; i++) step(1'b0, 1'b0, 8'($urandom));
                step(1'b1, 1'b0, pat(l, x));
            end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        cap_mode = 0;
        chk("gap_count", 64'(q_b.size()), 64'd48);
        for (int i = 0; i < q_b.size() && i < q_a.size(); i++)
            chk($sformatf("gap_seq%0d", i), q_b[i], q_a[i]);

        // mid-line sof at x=5 of line 10
        for (int x = 0; x < 5; x++) step(1'b1, 1'b0, pat(10, x));
        step(1'b1, 1'b1, 8'hC3);
        step(1'b0, 1'b0, 8'h00);
        chk("sof_we", 64'(ram_we), 64'h80);
        chk("sof_addr", 64'(ram_addr), 64'h0);
        chk("sof_wdata", 64'(ram_wdata), 64'hC3);
        for (int i = 1; i < 9 * W; i++) step(1'b1, 1'b0, 8'($urandom));

        // randomized traffic with occasional sof and reset
        for (int i = 0; i < 3000; i++) begin
            logic v, s;
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                step(1'b1, 1'b0, 8'($urandom));
                rst_n = 1'b1;
            end
            v = ($urandom_range(0, 9) < 7);
            s = v ? ($urandom_range(0, 299) == 0) : 1'($urandom_range(0, 1));
            step(v, s, 8'($urandom));
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
